// File: rtl/noc_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one NoC output channel between requesters.
// A grant is held from the first beat to the last beat (or a forced release after max_burst beats).
module noc_rr_arbiter #(
    parameter int width      = 32,
    parameter int num_inputs = 4,
    parameter int max_burst  = 256,
    localparam int iw = $clog2(num_inputs),
    localparam int bw = $clog2(max_burst + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [num_inputs*width-1:0]   in_bus,
    input  logic [num_inputs-1:0]         in_valid,
    input  logic [num_inputs-1:0]         in_last,
    output logic [num_inputs-1:0]         in_ready,
    output logic [width-1:0]              out_data,
    output logic                          out_valid,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic                          grant_valid,
    output logic [iw-1:0]                 grant_id,
    output logic                          err_overrun
);

    // Handshake: a beat moves when out_valid and out_ready are both high in the same cycle;
    // in_ready mirrors out_ready onto the granted requester only.
    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_n;
    logic [iw-1:0]   ptr, ptr_n, grant_id_n, pick;
    logic [bw-1:0]   cnt, cnt_n;
    logic            pick_found, err_n, xfer;

    function automatic logic [iw-1:0] wrap_add(input logic [iw-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= num_inputs) s = s - num_inputs;
        return iw'(s);
    endfunction

    assign grant_valid = (state == GRANT);
    assign out_data    = in_bus[grant_id*width +: width];
    assign out_last    = in_last[grant_id];
    assign out_valid   = grant_valid & in_valid[grant_id];
    assign xfer        = out_valid & out_ready;

    always_comb begin
        in_ready = '0;
        if (grant_valid && out_ready) in_ready[grant_id] = 1'b1;
    end

    // First requester at or after ptr, scanning circularly.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        for (int k = 0; k < num_inputs; k++) begin
            if (!pick_found && in_valid[wrap_add(ptr, k)]) begin
                pick_found = 1'b1;
                pick       = wrap_add(ptr, k);
            end
        end
    end

    always_comb begin
        state_n    = state;
        grant_id_n = grant_id;
        ptr_n      = ptr;
        cnt_n      = cnt;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_id_n = pick;
                    ptr_n      = (pick == iw'(num_inputs - 1)) ? '0 : pick + iw'(1);
                    cnt_n      = '0;
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (out_last) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + bw'(1);
                        if (cnt_n == bw'(max_burst)) begin
                            state_n = IDLE;
                            err_n   = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_id    <= '0;
            ptr         <= '0;
            cnt         <= '0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_n;
            grant_id    <= grant_id_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            err_overrun <= err_n;
        end
    end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Bench for noc_rr_arbiter: two instances (max_burst 256 and 4) share stimulus and are
// compared each cycle against a packet-level model built from the arbitration rules.
module tb_noc_rr_arbiter;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 1 + IW + 1 + 1 + N + 1 + W;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N*W-1:0] in_bus;
    logic [N-1:0]   in_valid, in_last;
    logic           out_ready;

    logic [N-1:0]  rdy0, rdy1;
    logic [W-1:0]  d0, d1;
    logic          v0, v1, l0, l1, gv0, gv1, e0, e1;
    logic [IW-1:0] gi0, gi1;

    noc_rr_arbiter #(.width(W), .num_inputs(N), .max_burst(256)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy0), .out_data(d0), .out_valid(v0), .out_last(l0), .out_ready(out_ready),
        .grant_valid(gv0), .grant_id(gi0), .err_overrun(e0));

    noc_rr_arbiter #(.width(W), .num_inputs(N), .max_burst(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy1), .out_data(d1), .out_valid(v1), .out_last(l1), .out_ready(out_ready),
        .grant_valid(gv1), .grant_id(gi1), .err_overrun(e1));

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: per instance, who holds the channel and how many beats it has sent.
    bit          mg[2];
    int          mid[2], mptr[2], mcnt[2];
    bit          merr[2];
    int          mb[2] = '{256, 4};
    logic [CW-1:0] e_vec[2];
    bit          e_xfer[2];
    logic [W-1:0] exp_q[$];

    function automatic logic [CW-1:0] get_obs(input int m);
        if (m == 0) return {gv0, gi0, v0, l0, rdy0, e0, d0};
        return {gv1, gi1, v1, l1, rdy1, e1, d1};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mg[m] = 0; mid[m] = 0; mptr[m] = 0; mcnt[m] = 0; merr[m] = 0;
        end
    endtask

    task automatic settle();
        logic ev;
        logic [N-1:0] er;
        #1;
        if (!rst_n) model_reset();
        for (int m = 0; m < 2; m++) begin
            ev = mg[m] && in_valid[mid[m]];
            er = (mg[m] && out_ready) ? (N'(1) << mid[m]) : '0;
            e_xfer[m] = ev && out_ready;
            e_vec[m] = {mg[m], IW'(mid[m]), ev, in_last[mid[m]], er, merr[m], in_bus[mid[m]*W +: W]};
        end
    endtask

    task automatic advance();
        int idx;
        bit found;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                merr[m] = 0;
                if (!mg[m]) begin
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        idx = (mptr[m] + k) % N;
                        if (!found && in_valid[idx]) begin
                            found = 1; mg[m] = 1; mid[m] = idx; mptr[m] = (idx + 1) % N; mcnt[m] = 0;
                        end
                    end
                end else if (e_xfer[m]) begin
                    if (in_last[mid[m]]) begin
                        mg[m] = 0;
                    end else begin
                        mcnt[m]++;
                        if (mcnt[m] == mb[m]) begin
                            mg[m] = 0; merr[m] = 1;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_bus();
        for (int i = 0; i < N; i++) in_bus[i*W +: W] = $urandom();
    endtask

    task automatic do_reset();
        in_valid = '0; in_last = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        settle();
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        randomize_bus();
        in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
        rst_n = 1'b0;
        settle();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (get_obs(m) !== e_vec[m]) begin
                n_fail++; $display("FAIL reset_hold[%0d]: got %h want %h", m, get_obs(m), e_vec[m]);
            end
        end
        n_cmp++;
        if ({rdy0, v0, gv0, rdy1, v1, gv1} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0", {rdy0, v0, gv0, rdy1, v1, gv1});
        end
        advance();
        rst_n = 1'b1;
        settle();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (get_obs(m) !== e_vec[m]) begin
                n_fail++; $display("FAIL reset_release[%0d]: got %h want %h", m, get_obs(m), e_vec[m]);
            end
        end
        advance();
        settle();
        n_cmp++;
        if (gv0 !== 1'b1 || gi0 !== 2'd0) begin
            n_fail++; $display("FAIL reset_first_grant: got gv=%b id=%0d want gv=1 id=0", gv0, gi0);
        end
    endtask

    task automatic test_round_robin();
        int nxt = 0;
        do_reset();
        in_valid = '1; in_last = '1; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            randomize_bus();
            settle();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (get_obs(m) !== e_vec[m]) begin
                    n_fail++; $display("FAIL rr[%0d] c=%0d: got %h want %h", m, c, get_obs(m), e_vec[m]);
                end
            end
            if (v0 && out_ready) begin
                n_cmp++;
                if (gi0 !== IW'(nxt % N)) begin
                    n_fail++; $display("FAIL rr_order: got %0d want %0d", gi0, nxt % N);
                end
                nxt++;
            end
            advance();
        end
        n_cmp++;
        if (nxt != 5) begin
            n_fail++; $display("FAIL rr_count: got %0d beats want 5", nxt);
        end
    endtask

    task automatic test_packet_lock();
        int b = 0;
        int last_c = -1;
        bit done = 0;
        do_reset();
        randomize_bus();
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_valid = (c == 0) ? 4'b0010 : 4'b0110;
            in_last  = 4'b0010;
            settle();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (get_obs(m) !== e_vec[m]) begin
                    n_fail++; $display("FAIL lock_pre[%0d]: got %h want %h", m, get_obs(m), e_vec[m]);
                end
            end
            advance();
        end
        for (int c = 0; c < 40 && !done; c++) begin
            randomize_bus();
            in_valid = 4'b0110;
            in_last = 4'b0010;
            in_last[2] = (b == 4);
            out_ready = (c % 2 == 0);
            settle();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (get_obs(m) !== e_vec[m]) begin
                    n_fail++; $display("FAIL lock[%0d] c=%0d: got %h want %h", m, c, get_obs(m), e_vec[m]);
                end
            end
            if (e_xfer[0] && mid[0] == 2) begin
                b++;
                if (b == 5) last_c = c;
            end
            if (last_c >= 0 && c == last_c + 2) begin
                n_cmp++;
                if (gv0 !== 1'b1 || gi0 !== 2'd1) begin
                    n_fail++; $display("FAIL lock_next_grant: got gv=%b id=%0d want gv=1 id=1", gv0, gi0);
                end
                done = 1;
            end
            advance();
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL lock_timeout: got %0d beats want 5", b);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_valid_gaps();
        logic [W-1:0] src[4];
        logic [W-1:0] got;
        int bi = 0;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            src[i] = $urandom();
            exp_q.push_back(src[i]);
        end
        for (int c = 0; c < 16; c++) begin
            randomize_bus();
            if (bi < 4) in_bus[0 +: W] = src[bi];
            in_valid  = 4'b0000;
            in_valid[0] = (bi < 4) && !(c >= 3 && c <= 5);
            in_last   = 4'b0000;
            in_last[0] = (bi == 3);
            out_ready = !(c >= 6 && c <= 8);
            settle();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (get_obs(m) !== e_vec[m]) begin
                    n_fail++; $display("FAIL gaps[%0d] c=%0d: got %h want %h", m, c, get_obs(m), e_vec[m]);
                end
            end
            if (c >= 3 && c <= 5) begin
                n_cmp++;
                if (gv0 !== 1'b1 || v0 !== 1'b0) begin
                    n_fail++; $display("FAIL gap_hold c=%0d: got gv=%b ov=%b want gv=1 ov=0", c, gv0, v0);
                end
            end
            if (!out_ready) begin
                n_cmp++;
                if (rdy0 !== 4'b0000) begin
                    n_fail++; $display("FAIL stall_ready c=%0d: got %b want 0000", c, rdy0);
                end
            end
            if (v0 && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL gaps_extra_beat: got %h want none", d0);
                end else begin
                    got = exp_q.pop_front();
                    if (d0 !== got) begin
                        n_fail++; $display("FAIL gaps_data: got %h want %h", d0, got);
                    end
                end
            end
            if (rdy0[0] && in_valid[0]) bi++;
            advance();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL gaps_lost_beats: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_overrun();
        int err_cnt = 0;
        do_reset();
        in_last = '0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            randomize_bus();
            in_valid = (c >= 5) ? 4'b1111 : 4'b1000;
            settle();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (get_obs(m) !== e_vec[m]) begin
                    n_fail++; $display("FAIL overrun[%0d] c=%0d: got %h want %h", m, c, get_obs(m), e_vec[m]);
                end
            end
            if (e1) err_cnt++;
            if (c == 5) begin
                n_cmp++;
                if (gv1 !== 1'b0 || e1 !== 1'b1) begin
                    n_fail++; $display("FAIL overrun_release: got gv=%b err=%b want gv=0 err=1", gv1, e1);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (gv1 !== 1'b1 || gi1 !== 2'd0 || e1 !== 1'b0) begin
                    n_fail++; $display("FAIL overrun_next: got gv=%b id=%0d err=%b want 1/0/0", gv1, gi1, e1);
                end
            end
            advance();
        end
        n_cmp++;
        if (err_cnt != 1) begin
            n_fail++; $display("FAIL overrun_pulses: got %0d want 1", err_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        randomize_bus();
        in_valid = 4'b0010; in_last = '0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (get_obs(m) !== e_vec[m]) begin
                    n_fail++; $display("FAIL areset_pre[%0d] c=%0d: got %h want %h", m, c, get_obs(m), e_vec[m]);
                end
            end
            if (c < 2) advance();
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gv0, rdy0, v0, gv1, rdy1, v1} !== '0) begin
            n_fail++; $display("FAIL areset_drop: got %b want 0", {gv0, rdy0, v0, gv1, rdy1, v1});
        end
        settle();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (get_obs(m) !== e_vec[m]) begin
                n_fail++; $display("FAIL areset_state[%0d]: got %h want %h", m, get_obs(m), e_vec[m]);
            end
        end
        advance();
        rst_n = 1'b1;
        in_valid = 4'b1111;
        settle();
        advance();
        settle();
        n_cmp++;
        if (gv0 !== 1'b1 || gi0 !== 2'd0) begin
            n_fail++; $display("FAIL areset_restart: got gv=%b id=%0d want gv=1 id=0", gv0, gi0);
        end
    endtask

    task automatic test_random();
        int rem[N];
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 6);
        for (int c = 0; c < 400; c++) begin
            randomize_bus();
            for (int i = 0; i < N; i++) begin
                in_valid[i] = ($urandom_range(0, 3) != 0);
                in_last[i]  = (rem[i] == 1);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            settle();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (get_obs(m) !== e_vec[m]) begin
                    n_fail++; $display("FAIL random[%0d] c=%0d: got %h want %h", m, c, get_obs(m), e_vec[m]);
                end
            end
            if (e_xfer[0]) begin
                rem[mid[0]]--;
                if (rem[mid[0]] == 0) rem[mid[0]] = $urandom_range(1, 6);
            end
            advance();
        end
    endtask

    initial begin
        in_bus = '0; in_valid = '0; in_last = '0; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_valid_gaps();
        test_overrun();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
